uart_receiver: RTL and testbench

//  Serial-to-parallel UART receive stage; counterpart of the 8N1 serial transmitter on the same link.

---
 rtl/uart_receiver_if.sv | 30 +++
 rtl/uart_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_receiver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receiver-side bus: serial line in, held byte with ready/error flags out,
// consumer acknowledge back in.
interface uart_receiver_if;
    logic       rx;
    logic       rd;
    logic [7:0] dout;
    logic       drl;
    logic       ferr;
    logic       ovr;

    // Line driver and byte consumer
    modport master (
        output rx,
        output rd,
        input  dout,
        input  drl,
        input  ferr,
        input  ovr
    );

    // The receiver itself
    modport slave (
        input  rx,
        input  rd,
        output dout,
        output drl,
        output ferr,
        output ovr
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage. Samples each bit at its centre using a down-counter
// timed from the start-bit falling edge, and holds the received byte with a
// level ready flag until the consumer acknowledges it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a falling edge on the synchronised line
// S_START | counting to mid start bit; rx_s=1 there means a glitch
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | counting to mid stop bit; 1 commits the byte, 0 is a framing error
// S_BREAK | line held low after a framing error; wait for it to return high
module uart_receiver #(
    parameter logic [15:0] BIT_RATE_VAL = 16'h01B0
) (
    input  logic           clk,
    input  logic           res,
    uart_receiver_if.slave bus
);

    // The transmitter's bit period is its rate constant plus three cycles of
    // its own handshake overhead; matching it exactly keeps samples centred.
    localparam logic [15:0] P    = BIT_RATE_VAL + 16'd3;
    localparam logic [15:0] HALF = P >> 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic        rx_p;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic [7:0]  dout_r;
    logic        drl_r;
    logic        ferr_r;
    logic        ovr_r;

    logic fall;
    logic expiry;

    assign fall   = rx_p & ~rx_s;
    assign expiry = (cnt == 16'd0);

    assign bus.dout = dout_r;
    assign bus.drl  = drl_r;
    assign bus.ferr = ferr_r;
    assign bus.ovr  = ovr_r;

    // Two-flop synchroniser plus a delay flop for falling-edge detection
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // Frame FSM with bit timer, shift register and registered output flags
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state  <= S_IDLE;
            cnt    <= 16'd0;
            idx    <= 3'd0;
            shreg  <= 8'h00;
            dout_r <= 8'h00;
            drl_r  <= 1'b0;
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            ferr_r <= 1'b0;

            // Acknowledge first; a commit in the same cycle overrides drl below
            if (bus.rd && drl_r) begin
                drl_r <= 1'b0;
                ovr_r <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        cnt   <= HALF - 16'd1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (expiry) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= P - 16'd1;
                            idx   <= 3'd0;
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (expiry) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= P - 16'd1;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (expiry) begin
                        if (rx_s) begin
                            dout_r <= shreg;
                            drl_r  <= 1'b1;
                            if (drl_r && !bus.rd) begin
                                ovr_r <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            ferr_r <= 1'b1;
                            state  <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected bytes, a
// negedge monitor pops and compares whenever a new byte is presented.
module tb_uart_receiver;

    localparam logic [15:0] BRV  = 16'd13;
    localparam int          P    = 16;   // BRV + 3
    localparam int          HALF = 8;    // P >> 1

    logic clk = 1'b0;
    logic res = 1'b1;

    uart_receiver_if bus ();

    uart_receiver #(.BIT_RATE_VAL(BRV)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_drl  = 1'b0;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] exp_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a commit shows up as drl rising or dout changing while drl=1
    always @(negedge clk) begin
        if (res) begin
            if (bus.ferr) ferr_cnt++;
            if (bus.drl && (!prev_drl || bus.dout != prev_dout)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_commit: got %0h expected none", bus.dout);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("commit_dout", {24'd0, bus.dout}, {24'd0, exp_b});
                end
            end
        end
        prev_drl  = bus.drl;
        prev_dout = bus.dout;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(P);
        end
        bus.rx = stop_bit;
        tick(P);
    endtask

    task automatic rd_pulse();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        #2 res = 1'b0;
        #1;
        chk("reset_drl",  {31'd0, bus.drl},  32'd0);
        chk("reset_dout", {24'd0, bus.dout}, 32'd0);
        chk("reset_ferr", {31'd0, bus.ferr}, 32'd0);
        chk("reset_ovr",  {31'd0, bus.ovr},  32'd0);
        tick(3);
        res = 1'b1;
        tick(2);

        // 1: plain frame, then acknowledge
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        tick(4);
        chk("t1_drl",  {31'd0, bus.drl}, 32'd1);
        chk("t1_ovr",  {31'd0, bus.ovr}, 32'd0);
        chk("t1_ferr", ferr_cnt,         32'd0);
        rd_pulse();
        chk("t1_drl_after_rd", {31'd0, bus.drl}, 32'd0);

        // 2: short glitch is a false start
        bus.rx = 1'b0;
        tick(HALF - 4);
        bus.rx = 1'b1;
        tick(2 * P);
        chk("t2_drl",  {31'd0, bus.drl},  32'd0);
        chk("t2_ferr", ferr_cnt,          32'd0);
        chk("t2_dout", {24'd0, bus.dout}, 32'hA5);

        // 3: framing error followed by a held-low line, then recovery
        send(8'h3C, 1'b0);
        tick(3 * P);
        bus.rx = 1'b1;
        tick(P);
        chk("t3_ferr", ferr_cnt,          32'd1);
        chk("t3_drl",  {31'd0, bus.drl},  32'd0);
        chk("t3_dout", {24'd0, bus.dout}, 32'hA5);
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1);
        tick(4);
        chk("t3_drl_after_01", {31'd0, bus.drl}, 32'd1);
        rd_pulse();

        // 4: back-to-back frames without acknowledge -> overrun
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        tick(4);
        chk("t4_dout", {24'd0, bus.dout}, 32'h22);
        chk("t4_drl",  {31'd0, bus.drl},  32'd1);
        chk("t4_ovr",  {31'd0, bus.ovr},  32'd1);
        rd_pulse();
        chk("t4_drl_after_rd", {31'd0, bus.drl}, 32'd0);
        chk("t4_ovr_after_rd", {31'd0, bus.ovr}, 32'd0);

        // 5: acknowledge exactly in the commit cycle (edge 3 + HALF + 9*P = 155)
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        tick(4);
        chk("t5_drl_55", {31'd0, bus.drl}, 32'd1);
        exp_q.push_back(8'h66);
        fork
            send(8'h66, 1'b1);
            begin
                tick(3 + HALF + 9 * P - 1);
                bus.rd = 1'b1;
                tick(1);
                bus.rd = 1'b0;
            end
        join
        tick(4);
        chk("t5_dout", {24'd0, bus.dout}, 32'h66);
        chk("t5_drl",  {31'd0, bus.drl},  32'd1);
        chk("t5_ovr",  {31'd0, bus.ovr},  32'd0);

        // 6: reset mid-DATA aborts the frame
        fork
            send(8'hFF, 1'b1);
            begin
                tick(4 * P);
                res = 1'b0;
                #1;
                chk("t6_drl_rst",  {31'd0, bus.drl},  32'd0);
                chk("t6_dout_rst", {24'd0, bus.dout}, 32'd0);
                chk("t6_ovr_rst",  {31'd0, bus.ovr},  32'd0);
                tick(2);
                res = 1'b1;
            end
        join
        tick(P);
        chk("t6_no_commit", {31'd0, bus.drl}, 32'd0);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        tick(4);
        chk("t6_drl_81", {31'd0, bus.drl}, 32'd1);

        tick(4);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
